xif_offload_issuer: RTL and testbench
=====================================

Name: xif_offload_issuer

Overview:
Core-side initiator of the eXtension interface: takes one offloaded instruction from the pipeline and drives the issue, commit and result phases to a coprocessor such as the AES unit. It then returns either a register writeback or an illegal-instruction indication to the pipeline. Only one transaction is outstanding at a time; transaction IDs come from a wrapping counter. It sits between the core's ID/EX stage and the XIF coprocessor ports.

Parameters:
X_ID_WIDTH, 4, width of transaction ID
X_RFR_WIDTH, 32, operand/result data width
TIMEOUT_CYCLES, 256, result watchdog limit (optional feature only)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
instr_valid_i  in  1  pipeline presents offload candidate
instr_ready_o  out  1  block can take instruction (state==IDLE)
instr_i  in  32  instruction word
rs1_i, rs2_i  in  X_RFR_WIDTH  operand values
rs_valid_i  in  2  operand valid bits {rs2,rs1}
kill_i  in  1  pipeline flush of the in-flight instruction
illegal_o  out  1  1-cycle pulse: coprocessor rejected instruction
wb_valid_o  out  1  1-cycle writeback pulse
wb_rd_o  out  5  writeback register address
wb_data_o  out  X_RFR_WIDTH  writeback data
id_err_o  out  1  1-cycle pulse: result with unexpected ID consumed
timeout_o  out  1  1-cycle pulse: result watchdog expired
issue_valid_o  out  1  XIF issue request valid
issue_ready_i  in  1  XIF issue ready
issue_instr_o  out  32  issued instruction
issue_id_o  out  X_ID_WIDTH  issued ID
issue_rs0_o, issue_rs1_o  out  X_RFR_WIDTH  operands
issue_rs_valid_o  out  3  {1'b0, rs_valid}
issue_accept_i  in  1  coprocessor accepts
issue_writeback_i  in  1  coprocessor will write rd
commit_valid_o  out  1  commit strobe
commit_id_o  out  X_ID_WIDTH  committed ID
commit_kill_o  out  1  kill flag
result_valid_i  in  1  result valid
result_ready_o  out  1  result ready
result_id_i  in  X_ID_WIDTH  result ID
result_data_i  in  X_RFR_WIDTH  result data
result_rd_i  in  5  result destination
result_we_i  in  1  result write enable

Behaviour:
- Reset: state IDLE, ID counter 0, kill_pending 0. All outputs 0 except instr_ready_o=1 and result_ready_o=0. Reset mid-transaction abandons it; no commit is sent.
- FSM states: IDLE, ISSUE, COMMIT, WAIT_RESULT.
- IDLE: on instr_valid_i (ready=1), register instr, operands and rs_valid; go to ISSUE. kill_i is ignored in IDLE.
- ISSUE: issue_valid_o=1; all issue_* outputs come from registers and hold stable until issue_ready_i. issue_valid_o is never withdrawn before the handshake, even on kill_i. A kill_i in ISSUE sets kill_pending.
- ISSUE handshake: the ID counter increments and wraps modulo 2^X_ID_WIDTH on every handshake.
  - accept=0: illegal_o pulses next cycle (suppressed if kill_pending or kill_i); go to IDLE; no commit.
  - accept=1: go to COMMIT; the writeback flag is latched.
- COMMIT: commit_valid_o=1 for exactly one cycle with commit_id_o = issued ID and commit_kill_o = kill_pending|kill_i.
  - Killed: go to IDLE and clear kill_pending.
  - Otherwise: go to WAIT_RESULT.
- WAIT_RESULT: result_ready_o=1; kill_i is ignored (already committed).
  - Result handshake with matching ID: if result_we_i & latched writeback, the next cycle wb_valid_o=1, wb_rd_o=result_rd_i, wb_data_o=result_data_i. Go to IDLE.
  - ID mismatch: result consumed, id_err_o pulses, stay in WAIT_RESULT.
- wb_rd_o/wb_data_o hold their last value when wb_valid_o=0.
- Minimum latency with all readies tied high: instr handshake t0, issue_valid t1, commit t2, result accepted t3, wb_valid t4. A new instruction can be accepted at t4, concurrent with wb_valid.

Optional Feature:
XIF_OFFLOAD_TIMEOUT_EN
- Defined: a counter clears on entry to WAIT_RESULT and increments each cycle without a matching result. On reaching TIMEOUT_CYCLES: timeout_o pulses, no writeback, go to IDLE. A later stale result is not accepted in IDLE (result_ready_o=0).
- Undefined: no counter; timeout_o is tied 0; the block waits indefinitely.

Test Plan:
- AES instr 0x... (opcode AES32), rs1=0x00112233, rs2=0x44556677, readies=1, accept=1, writeback=1, result ID 0 data 0xDEADBEEF rd=5 -> commit at t2 with kill=0; wb_valid at t4 with rd=5, data 0xDEADBEEF.
- accept=0 -> illegal_o single pulse, no commit_valid, ID counter still advances to 1.
- issue_ready_i low 3 cycles with kill_i pulsed in second -> issue_* stable; after handshake commit_kill_o=1; no wb; back to IDLE.
- Result with ID 3 while expecting 2, then ID 2 -> id_err_o pulse once, then writeback from ID 2.
- 17 back-to-back transactions -> issue_id_o sequence 0..15,0 (wrap).
- XIF_OFFLOAD_TIMEOUT_EN, TIMEOUT_CYCLES=8, no result -> timeout_o pulse after 8 WAIT_RESULT cycles, instr_ready_o=1 next cycle.

Source files
------------

// File: rtl/xif_offload_issuer.sv
// Core-side eXtension-interface initiator: issue -> commit -> result for one offloaded instruction.
// Optional result watchdog enabled by defining XIF_OFFLOAD_TIMEOUT_EN.
module xif_offload_issuer #(
  parameter int unsigned X_ID_WIDTH     = 4,
  parameter int unsigned X_RFR_WIDTH    = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   instr_valid_i,
  output logic                   instr_ready_o,
  input  logic [31:0]            instr_i,
  input  logic [X_RFR_WIDTH-1:0] rs1_i,
  input  logic [X_RFR_WIDTH-1:0] rs2_i,
  input  logic [1:0]             rs_valid_i,
  input  logic                   kill_i,
  output logic                   illegal_o,
  output logic                   wb_valid_o,
  output logic [4:0]             wb_rd_o,
  output logic [X_RFR_WIDTH-1:0] wb_data_o,
  output logic                   id_err_o,
  output logic                   timeout_o,
  output logic                   issue_valid_o,
  input  logic                   issue_ready_i,
  output logic [31:0]            issue_instr_o,
  output logic [X_ID_WIDTH-1:0]  issue_id_o,
  output logic [X_RFR_WIDTH-1:0] issue_rs0_o,
  output logic [X_RFR_WIDTH-1:0] issue_rs1_o,
  output logic [2:0]             issue_rs_valid_o,
  input  logic                   issue_accept_i,
  input  logic                   issue_writeback_i,
  output logic                   commit_valid_o,
  output logic [X_ID_WIDTH-1:0]  commit_id_o,
  output logic                   commit_kill_o,
  input  logic                   result_valid_i,
  output logic                   result_ready_o,
  input  logic [X_ID_WIDTH-1:0]  result_id_i,
  input  logic [X_RFR_WIDTH-1:0] result_data_i,
  input  logic [4:0]             result_rd_i,
  input  logic                   result_we_i
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, COMMIT, WAIT_RESULT} state_e;

  state_e                 state_q;
  logic [31:0]            instr_q;
  logic [X_RFR_WIDTH-1:0] rs1_q, rs2_q;
  logic [1:0]             rs_valid_q;
  logic [X_ID_WIDTH-1:0]  id_cnt_q, txn_id_q;
  logic                   kill_pend_q, wb_flag_q;
  logic                   illegal_q, wb_valid_q, id_err_q;
  logic [4:0]             wb_rd_q;
  logic [X_RFR_WIDTH-1:0] wb_data_q;
  logic                   kill_now;

`ifdef XIF_OFFLOAD_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt_q;
  logic            timeout_q;
`endif

  assign kill_now = kill_pend_q | kill_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      instr_q     <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rs_valid_q  <= '0;
      id_cnt_q    <= '0;
      txn_id_q    <= '0;
      kill_pend_q <= 1'b0;
      wb_flag_q   <= 1'b0;
      illegal_q   <= 1'b0;
      wb_valid_q  <= 1'b0;
      id_err_q    <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
`ifdef XIF_OFFLOAD_TIMEOUT_EN
      to_cnt_q    <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      illegal_q  <= 1'b0;
      wb_valid_q <= 1'b0;
      id_err_q   <= 1'b0;
`ifdef XIF_OFFLOAD_TIMEOUT_EN
      timeout_q  <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (instr_valid_i) begin
            instr_q    <= instr_i;
            rs1_q      <= rs1_i;
            rs2_q      <= rs2_i;
            rs_valid_q <= rs_valid_i;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          if (kill_i) kill_pend_q <= 1'b1;
          if (issue_ready_i) begin
            txn_id_q  <= id_cnt_q;
            id_cnt_q  <= id_cnt_q + 1'b1;
            wb_flag_q <= issue_writeback_i;
            if (issue_accept_i) begin
              state_q <= COMMIT;
            end else begin
              // Rejected: no commit follows, so the pending kill is dropped here.
              state_q     <= IDLE;
              kill_pend_q <= 1'b0;
              illegal_q   <= ~kill_now;
            end
          end
        end
        COMMIT: begin
          if (kill_now) begin
            state_q     <= IDLE;
            kill_pend_q <= 1'b0;
          end else begin
            state_q <= WAIT_RESULT;
`ifdef XIF_OFFLOAD_TIMEOUT_EN
            to_cnt_q <= '0;
`endif
          end
        end
        WAIT_RESULT: begin
          if (result_valid_i && (result_id_i == txn_id_q)) begin
            state_q <= IDLE;
            if (result_we_i && wb_flag_q) begin
              wb_valid_q <= 1'b1;
              wb_rd_q    <= result_rd_i;
              wb_data_q  <= result_data_i;
            end
          end else begin
            if (result_valid_i) id_err_q <= 1'b1;
`ifdef XIF_OFFLOAD_TIMEOUT_EN
            if (to_cnt_q == TO_LAST) begin
              timeout_q <= 1'b1;
              state_q   <= IDLE;
            end else begin
              to_cnt_q <= to_cnt_q + 1'b1;
            end
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign instr_ready_o    = (state_q == IDLE);
  assign issue_valid_o    = (state_q == ISSUE);
  assign issue_instr_o    = instr_q;
  assign issue_id_o       = id_cnt_q;
  assign issue_rs0_o      = rs1_q;
  assign issue_rs1_o      = rs2_q;
  assign issue_rs_valid_o = {1'b0, rs_valid_q};
  assign commit_valid_o   = (state_q == COMMIT);
  assign commit_id_o      = txn_id_q;
  assign commit_kill_o    = (state_q == COMMIT) & kill_now;
  assign result_ready_o   = (state_q == WAIT_RESULT);
  assign illegal_o        = illegal_q;
  assign wb_valid_o       = wb_valid_q;
  assign wb_rd_o          = wb_rd_q;
  assign wb_data_o        = wb_data_q;
  assign id_err_o         = id_err_q;
`ifdef XIF_OFFLOAD_TIMEOUT_EN
  assign timeout_o        = timeout_q;
`else
  assign timeout_o        = 1'b0;
`endif

endmodule

// File: tb/tb_xif_offload_issuer.sv
// Directed bench for xif_offload_issuer: transaction-level model with per-cycle output comparison.
// Define XIF_OFFLOAD_TIMEOUT_EN to also exercise the result watchdog (limit 8).
module tb_xif_offload_issuer;

  localparam int PH_IDLE = 0, PH_ISSUE = 1, PH_COMMIT = 2, PH_WAIT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid_i, instr_ready_o;
  logic [31:0] instr_i, rs1_i, rs2_i;
  logic [1:0]  rs_valid_i;
  logic        kill_i, illegal_o, wb_valid_o, id_err_o, timeout_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        issue_valid_o, issue_ready_i, issue_accept_i, issue_writeback_i;
  logic [31:0] issue_instr_o, issue_rs0_o, issue_rs1_o;
  logic [3:0]  issue_id_o, commit_id_o, result_id_i;
  logic [2:0]  issue_rs_valid_o;
  logic        commit_valid_o, commit_kill_o;
  logic        result_valid_i, result_ready_o, result_we_i;
  logic [31:0] result_data_i;
  logic [4:0]  result_rd_i;

  xif_offload_issuer #(.X_ID_WIDTH(4), .X_RFR_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o), .instr_i(instr_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rs_valid_i(rs_valid_i), .kill_i(kill_i),
    .illegal_o(illegal_o), .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .id_err_o(id_err_o), .timeout_o(timeout_o),
    .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i), .issue_instr_o(issue_instr_o),
    .issue_id_o(issue_id_o), .issue_rs0_o(issue_rs0_o), .issue_rs1_o(issue_rs1_o),
    .issue_rs_valid_o(issue_rs_valid_o), .issue_accept_i(issue_accept_i),
    .issue_writeback_i(issue_writeback_i),
    .commit_valid_o(commit_valid_o), .commit_id_o(commit_id_o), .commit_kill_o(commit_kill_o),
    .result_valid_i(result_valid_i), .result_ready_o(result_ready_o), .result_id_i(result_id_i),
    .result_data_i(result_data_i), .result_rd_i(result_rd_i), .result_we_i(result_we_i)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0, n_steps = 0;
  bit chk_en = 0;

  // Model state: next ID, last captured instruction, in-flight ID, last writeback.
  int          m_id, m_txn, e_iid;
  logic [31:0] m_instr, m_rs1, m_rs2;
  logic [1:0]  m_rsv;
  // Expected outputs for the current cycle.
  logic e_ready, e_iv, e_cv, e_rr, e_ckill, e_illegal, e_wb, e_iderr, e_to;
  logic [4:0]  e_rd;
  logic [31:0] e_data;
  // Pulses caused by the current cycle, visible next cycle.
  logic n_illegal, n_wb, n_iderr, n_to;
  logic [4:0]  n_rd;
  logic [31:0] n_data;
  int   seen_id;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("instr_ready", instr_ready_o, e_ready);
      chk("issue_valid", issue_valid_o, e_iv);
      if (e_iv) begin
        chk("issue_instr", issue_instr_o, m_instr);
        chk("issue_id", issue_id_o, e_iid);
        chk("issue_rs0", issue_rs0_o, m_rs1);
        chk("issue_rs1", issue_rs1_o, m_rs2);
        chk("issue_rs_valid", issue_rs_valid_o, {1'b0, m_rsv});
        seen_id = int'(issue_id_o);
      end
      chk("commit_valid", commit_valid_o, e_cv);
      if (e_cv) chk("commit_id", commit_id_o, m_txn);
      chk("commit_kill", commit_kill_o, e_ckill);
      chk("result_ready", result_ready_o, e_rr);
      chk("illegal", illegal_o, e_illegal);
      chk("wb_valid", wb_valid_o, e_wb);
      chk("wb_rd", wb_rd_o, e_rd);
      chk("wb_data", wb_data_o, e_data);
      chk("id_err", id_err_o, e_iderr);
      chk("timeout", timeout_o, e_to);
    end
  end

  task automatic set_phase(input int p);
    e_ready = (p == PH_IDLE);
    e_iv    = (p == PH_ISSUE);
    e_cv    = (p == PH_COMMIT);
    e_rr    = (p == PH_WAIT);
    e_ckill = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
    n_steps++;
    e_illegal = n_illegal; e_wb = n_wb; e_iderr = n_iderr; e_to = n_to;
    if (n_wb) begin e_rd = n_rd; e_data = n_data; end
    n_illegal = 0; n_wb = 0; n_iderr = 0; n_to = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_phase(PH_IDLE);
      instr_valid_i = 0; kill_i = 0; result_valid_i = 0;
      step();
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    instr_valid_i = 0; instr_i = '0; rs1_i = '0; rs2_i = '0; rs_valid_i = '0; kill_i = 0;
    issue_ready_i = 0; issue_accept_i = 0; issue_writeback_i = 0;
    result_valid_i = 0; result_id_i = '0; result_data_i = '0; result_rd_i = '0; result_we_i = 0;
    m_id = 0; m_txn = 0; e_rd = '0; e_data = '0;
    e_illegal = 0; e_wb = 0; e_iderr = 0; e_to = 0;
    n_illegal = 0; n_wb = 0; n_iderr = 0; n_to = 0;
    set_phase(PH_IDLE);
    step(); step();
    rst_n = 1;
    step();
  endtask

  // mode: 0 normal, 1 abandon in WAIT_RESULT after 'delay' cycles, 2 expect watchdog after 'delay' cycles
  task automatic txn(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                     input logic [1:0] rsv, input int stall, input int kill_at,
                     input logic acc, input logic wbf, input int delay,
                     input logic bad, input logic [3:0] bad_id, input logic [4:0] rd,
                     input logic [31:0] data, input logic we, input int mode);
    bit killp;
    int tid;
    set_phase(PH_IDLE);
    instr_valid_i = 1; instr_i = ins; rs1_i = a; rs2_i = b; rs_valid_i = rsv;
    kill_i = 1; result_valid_i = 0;
    step();
    m_instr = ins; m_rs1 = a; m_rs2 = b; m_rsv = rsv;
    instr_valid_i = 0; instr_i = ~ins; rs1_i = ~a; rs2_i = ~b; rs_valid_i = ~rsv; kill_i = 0;
    killp = 0; tid = 0;
    for (int c = 0; c <= stall; c++) begin
      set_phase(PH_ISSUE);
      e_iid = m_id;
      issue_ready_i = (c == stall); issue_accept_i = acc; issue_writeback_i = wbf;
      kill_i = (c == kill_at);
      if (kill_i) killp = 1;
      if (c == stall) begin
        tid = m_id;
        m_id = (m_id + 1) % 16;
        if (!acc && !killp) n_illegal = 1;
      end
      step();
    end
    issue_ready_i = 0; issue_accept_i = 0; issue_writeback_i = 0; kill_i = 0;
    if (!acc) return;
    set_phase(PH_COMMIT);
    m_txn = tid;
    kill_i = (kill_at == stall + 1);
    if (kill_i) killp = 1;
    e_ckill = killp;
    step();
    kill_i = 0;
    if (killp) return;
    for (int d = 0; d < delay; d++) begin
      set_phase(PH_WAIT);
      kill_i = 1; result_valid_i = 0;
      if (mode == 2 && d == delay - 1) n_to = 1;
      step();
    end
    kill_i = 0;
    if (mode != 0) return;
    if (bad) begin
      set_phase(PH_WAIT);
      result_valid_i = 1; result_id_i = bad_id; result_data_i = ~data; result_rd_i = ~rd;
      result_we_i = 1; n_iderr = 1;
      step();
    end
    set_phase(PH_WAIT);
    result_valid_i = 1; result_id_i = 4'(m_txn); result_data_i = data; result_rd_i = rd;
    result_we_i = we;
    if (we && wbf) begin n_wb = 1; n_rd = rd; n_data = data; end
    step();
    result_valid_i = 0; result_we_i = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n0;
    rst_n = 0;
    do_reset();
    chk_en = 1;
    idle(1);
    chk("rst_instr_ready", instr_ready_o, 1);
    chk("rst_result_ready", result_ready_o, 0);
    chk("rst_wb_data", wb_data_o, 0);

    // Minimum-latency AES32 transaction.
    n0 = n_steps;
    txn(32'h2220_8533, 32'h0011_2233, 32'h4455_6677, 2'b11, 0, -1, 1, 1, 0,
        0, 4'h0, 5'd5, 32'hDEAD_BEEF, 1, 0);
    chk("t1_latency", n_steps - n0, 4);
    chk("t1_id", seen_id, 0);
    chk("t1_wb_valid", wb_valid_o, 1);
    chk("t1_wb_rd", wb_rd_o, 5);
    chk("t1_wb_data", wb_data_o, 32'hDEAD_BEEF);

    // Rejected instruction.
    txn(32'h0000_007B, 32'h1, 32'h2, 2'b01, 0, -1, 0, 0, 0, 0, 4'h0, 5'd0, 32'h0, 0, 0);
    chk("t2_illegal", illegal_o, 1);
    chk("t2_id", seen_id, 1);
    idle(1);

    // Wrong result ID first, then the right one.
    txn(32'h2600_0533, 32'hA5A5_0001, 32'h5A5A_0002, 2'b11, 0, -1, 1, 1, 1,
        1, 4'h3, 5'd9, 32'h0BAD_F00D, 1, 0);
    chk("t4_id", seen_id, 2);
    chk("t4_wb_rd", wb_rd_o, 9);
    chk("t4_wb_data", wb_data_o, 32'h0BAD_F00D);

    // Issue stall with kill in the second stalled cycle.
    txn(32'h2A00_0533, 32'h3, 32'h4, 2'b10, 3, 1, 1, 1, 0, 0, 4'h0, 5'd1, 32'h1111, 1, 0);
    chk("t3_idle", instr_ready_o, 1);
    chk("t3_no_wb", wb_valid_o, 0);
    chk("t3_wb_hold", wb_data_o, 32'h0BAD_F00D);
    idle(2);

    // Kill arriving in the commit cycle.
    txn(32'h2E00_0533, 32'h5, 32'h6, 2'b11, 0, 1, 1, 1, 0, 0, 4'h0, 5'd2, 32'h2222, 1, 0);
    // Accepted without writeback flag, then result without we.
    txn(32'h3200_0533, 32'h7, 32'h8, 2'b11, 1, -1, 1, 0, 2, 0, 4'h0, 5'd3, 32'h3333, 1, 0);
    txn(32'h3600_0533, 32'h9, 32'hA, 2'b11, 0, -1, 1, 1, 0, 0, 4'h0, 5'd4, 32'h4444, 0, 0);
    // Reject with kill on the handshake cycle: no illegal pulse.
    txn(32'h0000_107B, 32'hB, 32'hC, 2'b00, 1, 1, 0, 0, 0, 0, 4'h0, 5'd0, 32'h0, 0, 0);
    idle(1);
    chk("t7_id", seen_id, 7);

    // Abandon in WAIT_RESULT via reset.
    txn(32'h3A00_0533, 32'hD, 32'hE, 2'b11, 0, -1, 1, 1, 2, 0, 4'h0, 5'd6, 32'h6666, 1, 1);
    do_reset();
    idle(2);

    // Back-to-back, ID wraps after 15.
    for (int i = 0; i < 17; i++) begin
      txn(32'h2220_8533 ^ (i << 7), 32'h100 + i, 32'h200 + i, 2'b11, 0, -1, 1, 1, 0,
          0, 4'h0, 5'(i + 1), 32'hC000_0000 + i, 1, 0);
      chk("wrap_id", seen_id, i % 16);
    end
    chk("wrap_wb_data", wb_data_o, 32'hC000_0010);
    idle(2);

`ifdef XIF_OFFLOAD_TIMEOUT_EN
    n0 = n_steps;
    txn(32'h3E00_0533, 32'h1, 32'h2, 2'b11, 0, -1, 1, 1, 8, 0, 4'h0, 5'd7, 32'h7777, 1, 2);
    chk("to_latency", n_steps - n0, 11);
    chk("to_pulse", timeout_o, 1);
    chk("to_ready", instr_ready_o, 1);
    set_phase(PH_IDLE);
    result_valid_i = 1; result_id_i = 4'(m_txn); result_data_i = 32'h7777;
    result_rd_i = 5'd7; result_we_i = 1;
    step();
    result_valid_i = 0; result_we_i = 0;
    chk("to_stale_wb", wb_valid_o, 0);
    idle(2);
`endif

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
